// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-byte outputs of the UART receiver.
// The receiver uses the slave view; whatever drives the line and consumes bytes uses master.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  rx_in;
  logic [PRESC_W-1:0]    prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority per bit,
// start/data/parity/stop FSM with parity and framing error pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic                  rx_meta_reg, rx_s_reg;
  logic [PRESC_W-1:0]    edge_cnt_reg, edge_cnt_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [PRESC_W-1:0]    presc_reg, presc_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic [1:0]            samp_reg, samp_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
  logic                  par_bad_reg, par_bad_next;
  logic                  stop_bad_reg, stop_bad_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  par_err_reg, par_err_next;
  logic                  stp_err_reg, stp_err_next;

  logic [PRESC_W-1:0] half;
  logic at_s0, at_s1, at_dec, at_end, majority, start_det;

  // The line is asynchronous to clk; idle level is high so the flops reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= bus.rx_in;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign half      = presc_reg >> 1;
  assign at_s0     = (edge_cnt_reg == half - PRESC_W'(1));
  assign at_s1     = (edge_cnt_reg == half);
  assign at_dec    = (edge_cnt_reg == half + PRESC_W'(1));
  assign at_end    = (edge_cnt_reg == presc_reg - PRESC_W'(1));
  // Third sample is the live synchronized value at the decision edge.
  assign majority  = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s_reg) | (samp_reg[1] & rx_s_reg);
  assign start_det = (state_reg == IDLE) && !rx_s_reg;

  always_comb begin
    state_next      = state_reg;
    edge_cnt_next   = at_end ? '0 : edge_cnt_reg + PRESC_W'(1);
    bit_cnt_next    = bit_cnt_reg;
    presc_next      = presc_reg;
    par_en_next     = par_en_reg;
    par_typ_next    = par_typ_reg;
    samp_next       = samp_reg;
    shift_next      = shift_reg;
    p_data_next     = p_data_reg;
    par_bad_next    = par_bad_reg;
    stop_bad_next   = stop_bad_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    if (at_s0) samp_next[0] = rx_s_reg;
    if (at_s1) samp_next[1] = rx_s_reg;

    case (state_reg)
      IDLE: begin
        edge_cnt_next = '0;
        if (start_det) begin
          // The detection cycle is edge 0 of the start bit.
          state_next    = START;
          edge_cnt_next = PRESC_W'(1);
          bit_cnt_next  = '0;
          presc_next    = bus.prescale;
          par_en_next   = bus.par_en;
          par_typ_next  = bus.par_typ;
          par_bad_next  = 1'b0;
          stop_bad_next = 1'b0;
        end
      end
      START: begin
        if (at_dec && majority) begin
          state_next    = IDLE;
          edge_cnt_next = '0;
        end else if (at_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (at_dec) shift_next = {majority, shift_reg[DATA_WIDTH-1:1]};
        if (at_end) begin
          if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (at_dec) par_bad_next = ((^shift_reg) ^ par_typ_reg) != majority;
        if (at_end) state_next = STOP;
      end
      STOP: begin
        if (at_dec) stop_bad_next = !majority;
        if (at_end) begin
          state_next      = IDLE;
          data_valid_next = !par_bad_reg && !stop_bad_reg;
          par_err_next    = par_bad_reg;
          stp_err_next    = stop_bad_reg;
          if (!par_bad_reg && !stop_bad_reg) p_data_next = shift_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      edge_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      presc_reg      <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      samp_reg       <= '0;
      shift_reg      <= '0;
      p_data_reg     <= '0;
      par_bad_reg    <= 1'b0;
      stop_bad_reg   <= 1'b0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      edge_cnt_reg   <= edge_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      presc_reg      <= presc_next;
      par_en_reg     <= par_en_next;
      par_typ_reg    <= par_typ_next;
      samp_reg       <= samp_next;
      shift_reg      <= shift_next;
      p_data_reg     <= p_data_next;
      par_bad_reg    <= par_bad_next;
      stop_bad_reg   <= stop_bad_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;
    end
  end

  assign bus.p_data     = p_data_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.par_err    = par_err_reg;
  assign bus.stp_err    = stp_err_reg;
  // Busy covers the detection cycle too, so a frame keeps it high for exactly N*P clocks.
  assign bus.busy       = (state_reg != IDLE) || start_det;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are described as bit lists and the expected
// pulses, their cycle of arrival, p_data and busy run lengths come from frame-level rules.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PW = 6;

  typedef struct {
    int             cyc;
    logic [2:0]     flags;   // {data_valid, par_err, stp_err}
    logic [DW-1:0]  data;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  evt_t exp_q[$];
  evt_t obs_q[$];
  int   busy_exp_q[$];
  int   busy_obs_q[$];
  int   busy_run = 0;
  int   busy_acc = 0;
  logic [DW-1:0] last_good = '0;

  uart_rx_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) bus ();

  uart_rx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse and every busy-high run, sampled mid-cycle.
  always @(negedge clk) begin
    evt_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        busy_obs_q.push_back(busy_run);
        busy_run = 0;
      end
      if (bus.data_valid || bus.par_err || bus.stp_err) begin
        e.cyc   = cyc;
        e.flags = {bus.data_valid, bus.par_err, bus.stp_err};
        e.data  = bus.p_data;
        obs_q.push_back(e);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    if (busy_acc > 0) busy_exp_q.push_back(busy_acc);
    busy_acc = 0;
    tick(n);
  endtask

  // Drives one complete frame, P clocks per bit, and predicts its outcome.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptyp,
                            input bit flip_par, input bit stop_bit, input bit noisy, input bit scramble);
    bit   bits[$];
    bit   pbit, pbad, sbad, flip;
    int   k0, off;
    evt_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    pbit = (^d) ^ ptyp ^ flip_par;
    if (pen) bits.push_back(pbit);
    bits.push_back(stop_bit);

    pbad = pen && (((^d) ^ ptyp) != pbit);
    sbad = !stop_bit;
    if (!pbad && !sbad) last_good = d;
    k0      = cyc;
    e.cyc   = k0 + 2 + bits.size() * p;
    e.flags = {!pbad && !sbad, pbad, sbad};
    e.data  = last_good;
    exp_q.push_back(e);
    busy_acc += bits.size() * p;
    $display("frame data=%02h P=%0d par_en=%0b par_typ=%0b par_ok=%0b stop=%0b noisy=%0b",
             d, p, pen, ptyp, !flip_par, stop_bit, noisy);

    bus.prescale = PW'(p);
    bus.par_en   = pen;
    bus.par_typ  = ptyp;
    for (int b = 0; b < bits.size(); b++) begin
      // At most one of the three mid-bit samples is corrupted; the vote must absorb it.
      flip = noisy && (b > 0) && ($urandom_range(2) == 0);
      off  = $urandom_range(2);
      for (int c = 0; c < p; c++) begin
        bus.rx_in = bits[b] ^ (flip && (c == p / 2 - 1 + off));
        if (scramble && b == 1 && c == 0) begin
          bus.prescale = PW'(8 << $urandom_range(2));
          bus.par_en   = 1'($urandom);
          bus.par_typ  = 1'($urandom);
        end
        tick(1);
      end
    end
    bus.rx_in = stop_bit;
  endtask

  // A short low pulse: START gives up at the decision edge, P/2+1 edges after detection.
  task automatic glitch(input int p, input int len);
    bus.prescale = PW'(p);
    bus.rx_in    = 1'b0;
    tick(len);
    bus.rx_in = 1'b1;
    busy_exp_q.push_back(p / 2 + 2);
    $display("glitch P=%0d low=%0d", p, len);
    tick(p / 2 + 6);
  endtask

  task automatic flush();
    int n;
    check("event_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("event_cycle", obs_q[i].cyc, exp_q[i].cyc);
      check("event_flags_dv_pe_se", {29'd0, obs_q[i].flags}, {29'd0, exp_q[i].flags});
      check("event_p_data", {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
    end
    check("busy_run_count", busy_obs_q.size(), busy_exp_q.size());
    n = (busy_obs_q.size() < busy_exp_q.size()) ? busy_obs_q.size() : busy_exp_q.size();
    for (int i = 0; i < n; i++) check("busy_run_len", busy_obs_q[i], busy_exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    busy_obs_q.delete();
    busy_exp_q.delete();
  endtask

  initial begin
    int  p, gap;
    logic [DW-1:0] d;
    bit  pen, ptyp, fpar, sb, noisy, scr;

    bus.rx_in    = 1'b1;
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    rst = 1'b1;
    tick(3);
    check("reset_p_data", {24'd0, bus.p_data}, 32'd0);
    check("reset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("reset_par_err", {31'd0, bus.par_err}, 32'd0);
    check("reset_stp_err", {31'd0, bus.stp_err}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Good even-parity frame, then the same frame with a wrong parity bit.
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    flush();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(8);
    flush();

    // Stop bit low without parity.
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    flush();
    check("busy_after_stop_err", {31'd0, bus.busy}, 32'd0);

    glitch(8, 2);
    flush();

    // Back-to-back odd-parity frames at P=32.
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    flush();

    // Reset during the data bits of 0x5A, then a clean 0x81.
    $display("frame data=5a P=8 aborted by reset");
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      bus.rx_in = (8'h5A >> i) & 8'h01;
      tick(8);
    end
    rst       = 1'b1;
    bus.rx_in = 1'b1;
    tick(2);
    check("midrst_p_data", {24'd0, bus.p_data}, 32'd0);
    check("midrst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("midrst_par_err", {31'd0, bus.par_err}, 32'd0);
    check("midrst_stp_err", {31'd0, bus.stp_err}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    rst       = 1'b0;
    last_good = '0;
    tick(4);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    flush();

    // Random frames: mixed prescale, parity mode, errors, sample noise, config churn and gaps.
    for (int i = 0; i < 30; i++) begin
      p     = 8 << $urandom_range(2);
      d     = DW'($urandom);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      fpar  = ($urandom_range(3) == 0);
      sb    = ($urandom_range(3) != 0);
      noisy = 1'($urandom);
      scr   = 1'($urandom);
      send_frame(d, p, pen, ptyp, fpar, sb, noisy, scr);
      gap = $urandom_range(3);
      if (gap > 0) idle(gap);
      if (i % 10 == 9) begin
        idle(8);
        flush();
      end
    end
    idle(8);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
